// File: rtl/avmm_resp_pkg.sv
// -----------------------------------------------------------------------------
// avmm_resp_pkg
// Shared types and helpers for the Avalon-MM burst responder.
//   state_t     : command FSM states (IDLE, WR_BURST, RD_BURST)
//   BURST_W     : width of avs_burstcount
//   clamp_burst : effective burst length (0 -> 1, above max -> max)
// -----------------------------------------------------------------------------
package avmm_resp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  localparam int BURST_W = 16;

  function automatic logic [BURST_W-1:0] clamp_burst(
    input logic [BURST_W-1:0] len,
    input logic [BURST_W-1:0] max_len
  );
    logic [BURST_W-1:0] eff;
    if (len == '0)          eff = {{(BURST_W-1){1'b0}}, 1'b1};
    else if (len > max_len) eff = max_len;
    else                    eff = len;
    return eff;
  endfunction

endpackage

// File: rtl/avmm_burst_responder_resp_ram.sv
// -----------------------------------------------------------------------------
// resp_ram
// Simple dual-port word RAM: one write port, one read port, registered read
// (data appears the cycle after i_re). Contents are not reset.
// Ports:
//   clk                       clock
//   i_we / i_waddr / i_wdata  write port
//   i_re / i_raddr            read request
//   o_rdata                   read data, valid one cycle after i_re
// -----------------------------------------------------------------------------
module resp_ram
  import avmm_resp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/avmm_burst_responder.sv
// -----------------------------------------------------------------------------
// avmm_burst_responder
// Avalon-MM burst slave backed by on-chip RAM, used as the host side of the
// capture rd/wr controllers so the capture path can run without HPS/SDRAM.
// One burst is handled at a time.
// Ports:
//   clk, reset                synchronous active-high reset
//   avs_address               byte address (word index = bits [log2(DEPTH)+1:2])
//   avs_read / avs_write      commands; avs_write also qualifies write beats
//   avs_writedata             write data
//   avs_burstcount            beats per burst, sampled at command acceptance
//   avs_waitrequest           stall (high in reset and while a read burst runs)
//   avs_readdata/_readdatavalid  read beats, READ_LATENCY cycles after issue
//   proto_err                 sticky protocol error, cleared by reset only
//   stat_rd_beats/_wr_beats   beat counters (AVMM_RESP_STATS_EN), else 0
// Build option: define AVMM_RESP_STATS_EN to generate the saturating counters.
// -----------------------------------------------------------------------------
module avmm_burst_responder
  import avmm_resp_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int MAX_BURST    = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [DATA_W-1:0]  avs_writedata,
  input  logic [BURST_W-1:0] avs_burstcount,
  output logic               avs_waitrequest,
  output logic [DATA_W-1:0]  avs_readdata,
  output logic               avs_readdatavalid,
  output logic               proto_err,
  output logic [31:0]        stat_rd_beats,
  output logic [31:0]        stat_wr_beats
);

  localparam int                 AW        = $clog2(DEPTH);
  localparam logic [AW-1:0]      IDX_ONE   = AW'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
  localparam logic [BURST_W-1:0] MAX_B     = BURST_W'(MAX_BURST);

  // FSM and burst bookkeeping
  state_t             r_state, w_state_nxt;
  logic [AW-1:0]      r_idx, w_idx_nxt;
  logic [BURST_W-1:0] r_wr_rem, w_wr_rem_nxt;
  logic [BURST_W-1:0] r_iss_rem, w_iss_rem_nxt;  // read beats still to issue
  logic [BURST_W-1:0] r_ret_rem, w_ret_rem_nxt;  // read beats still to return
  logic               r_proto_err, w_err_set;

  // Command decode
  logic [AW-1:0]      w_cmd_idx;
  logic [BURST_W-1:0] w_cmd_len;
  logic               w_len_err;
  logic               w_unused_addr;

  // RAM ports
  logic               w_we, w_vld_p0;
  logic [AW-1:0]      w_waddr, w_raddr;
  logic [DATA_W-1:0]  w_wdata, w_ram_q;

  // Read return pipeline
  logic               r_vld_p1;
  logic               w_vld_out;
  logic [DATA_W-1:0]  w_rdata_out;

  assign w_cmd_idx     = avs_address[AW+1:2];
  assign w_cmd_len     = clamp_burst(avs_burstcount, MAX_B);
  assign w_len_err     = (avs_burstcount > MAX_B);
  assign w_unused_addr = ^{avs_address[31:AW+2], avs_address[1:0]};

  assign avs_waitrequest = reset | (r_state == RD_BURST);

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_wr_rem_nxt  = r_wr_rem;
    w_iss_rem_nxt = r_iss_rem;
    w_ret_rem_nxt = r_ret_rem;
    w_err_set     = 1'b0;
    w_we          = 1'b0;
    w_waddr       = r_idx;
    w_wdata       = avs_writedata;
    w_vld_p0      = 1'b0;
    w_raddr       = r_idx;
    // Nothing is accepted or issued while reset is high, so a reset cycle can
    // never touch the RAM contents.
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (avs_write) begin
            // A simultaneous read is dropped in favour of the write.
            w_we         = 1'b1;
            w_waddr      = w_cmd_idx;
            w_idx_nxt    = w_cmd_idx + IDX_ONE;
            w_wr_rem_nxt = w_cmd_len - BURST_ONE;
            w_err_set    = w_len_err | avs_read;
            if (w_cmd_len > BURST_ONE) w_state_nxt = WR_BURST;
          end else if (avs_read) begin
            w_idx_nxt     = w_cmd_idx;
            w_iss_rem_nxt = w_cmd_len;
            w_ret_rem_nxt = w_cmd_len;
            w_err_set     = w_len_err;
            w_state_nxt   = RD_BURST;
          end
        end
        WR_BURST: begin
          if (avs_read) w_err_set = 1'b1;
          if (avs_write) begin
            w_we         = 1'b1;
            w_idx_nxt    = r_idx + IDX_ONE;
            w_wr_rem_nxt = r_wr_rem - BURST_ONE;
            if (r_wr_rem == BURST_ONE) w_state_nxt = IDLE;
          end
        end
        RD_BURST: begin
          if (r_iss_rem != '0) begin
            w_vld_p0      = 1'b1;
            w_idx_nxt     = r_idx + IDX_ONE;
            w_iss_rem_nxt = r_iss_rem - BURST_ONE;
          end
          // Leave only once the final beat is on the bus.
          if (w_vld_out) begin
            w_ret_rem_nxt = r_ret_rem - BURST_ONE;
            if (r_ret_rem == BURST_ONE) w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_wr_rem    <= '0;
      r_iss_rem   <= '0;
      r_ret_rem   <= '0;
      r_proto_err <= 1'b0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_wr_rem    <= w_wr_rem_nxt;
      r_iss_rem   <= w_iss_rem_nxt;
      r_ret_rem   <= w_ret_rem_nxt;
      r_proto_err <= r_proto_err | w_err_set;
      r_vld_p1    <= w_vld_p0;
    end
  end

  assign proto_err = r_proto_err;

  // ---- p0 -> p1: RAM read, registered inside resp_ram ----
  resp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_vld_p0),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  // ---- p1 -> p2..: READ_LATENCY-1 output register stages ----
  generate
    if (READ_LATENCY > 1) begin : g_pipe
      logic [DATA_W-1:0] r_rdata_p2 [READ_LATENCY-1];
      logic              r_vld_p2   [READ_LATENCY-1];

      always_ff @(posedge clk) begin
        r_rdata_p2[0] <= w_ram_q;
        for (int i = 1; i < READ_LATENCY-1; i++) r_rdata_p2[i] <= r_rdata_p2[i-1];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < READ_LATENCY-1; i++) r_vld_p2[i] <= 1'b0;
        end else begin
          r_vld_p2[0] <= r_vld_p1;
          for (int i = 1; i < READ_LATENCY-1; i++) r_vld_p2[i] <= r_vld_p2[i-1];
        end
      end

      assign w_vld_out   = r_vld_p2[READ_LATENCY-2];
      assign w_rdata_out = r_rdata_p2[READ_LATENCY-2];
    end else begin : g_nopipe
      assign w_vld_out   = r_vld_p1;
      assign w_rdata_out = w_ram_q;
    end
  endgenerate

  // Data registers are not reset; the bus is forced quiet instead, which also
  // suppresses a beat already in flight on the cycle reset is raised.
  assign avs_readdatavalid = w_vld_out & ~reset;
  assign avs_readdata      = avs_readdatavalid ? w_rdata_out : '0;

`ifdef AVMM_RESP_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_stat_rd, r_stat_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_rd <= '0;
      r_stat_wr <= '0;
    end else begin
      if (w_vld_out) r_stat_rd <= sat_inc(r_stat_rd);
      if (w_we)      r_stat_wr <= sat_inc(r_stat_wr);
    end
  end

  assign stat_rd_beats = r_stat_rd;
  assign stat_wr_beats = r_stat_wr;
`else
  assign stat_rd_beats = '0;
  assign stat_wr_beats = '0;
`endif

endmodule

// File: tb/tb_avmm_burst_responder.sv
// -----------------------------------------------------------------------------
// tb_avmm_burst_responder
// Scoreboarded bench: read expectations (data + return cycle) are queued from
// a word-memory model when a read is driven, and popped when beats appear.
// -----------------------------------------------------------------------------
module tb_avmm_burst_responder;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int MAXB   = 256;
  localparam int RL     = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [DATA_W-1:0] avs_writedata = '0;
  logic [15:0]       avs_burstcount = '0;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;
  logic              proto_err;
  logic [31:0]       stat_rd_beats;
  logic [31:0]       stat_wr_beats;

  avmm_burst_responder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAXB), .READ_LATENCY(RL)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_burstcount    (avs_burstcount),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .proto_err         (proto_err),
    .stat_rd_beats     (stat_rd_beats),
    .stat_wr_beats     (stat_wr_beats)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Beat monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      if (sb.size() == 0) begin
        chk("rdv_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", avs_readdata, e.data);
        chk("rdv_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic int eff_len(input logic [15:0] bc);
    int b;
    b = int'(bc);
    if (b == 0) return 1;
    if (b > MAXB) return MAXB;
    return b;
  endfunction

  // Writes one burst; beat b carries base + b*step. A one-cycle avs_write gap
  // follows beat gap_after (-1 for none). Later beats drive junk address and
  // burstcount, which the responder must ignore.
  task automatic wr_burst(input logic [31:0] addr, input logic [15:0] bc,
                          input logic [31:0] base, input logic [31:0] step,
                          input int gap_after, input logic with_read);
    int idx, len;
    idx = int'(addr >> 2) % DEPTH;
    len = eff_len(bc);
    for (int b = 0; b < len; b++) begin
      avs_write     = 1'b1;
      avs_writedata = base + step * 32'(b);
      if (b == 0) begin
        avs_address    = addr;
        avs_burstcount = bc;
        avs_read       = with_read;
      end else begin
        avs_address    = 32'hFFFF_FFF0;
        avs_burstcount = 16'h0003;
        avs_read       = 1'b0;
      end
      mem_m[(idx + b) % DEPTH] = avs_writedata;
      #1;
      if (b < 4) chk("wr_waitreq", 32'(avs_waitrequest), 32'd0);
      @(posedge clk); #1;
      avs_read  = 1'b0;
      avs_write = 1'b0;
      if (b == gap_after) begin
        #1;
        chk("wr_gap_waitreq", 32'(avs_waitrequest), 32'd0);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic rd_burst(input logic [31:0] addr, input logic [15:0] bc);
    int idx, len, acc;
    idx = int'(addr >> 2) % DEPTH;
    len = eff_len(bc);
    acc = cyc;
    for (int b = 0; b < len; b++)
      sb.push_back('{data: mem_m[(idx + b) % DEPTH], cyc: acc + RL + 1 + b});
    avs_address    = addr;
    avs_burstcount = bc;
    avs_read       = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    chk("rd_waitreq_busy", 32'(avs_waitrequest), 32'd1);
    for (int t = 0; t < len + RL + 10 && sb.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("rd_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    chk("rd_waitreq_free", 32'(avs_waitrequest), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] rd, input logic [31:0] wr);
`ifdef AVMM_RESP_STATS_EN
    chk({tag, "_stat_rd"}, stat_rd_beats, rd);
    chk({tag, "_stat_wr"}, stat_wr_beats, wr);
`else
    chk({tag, "_stat_rd"}, stat_rd_beats, rd & 32'd0);
    chk({tag, "_stat_wr"}, stat_wr_beats, wr & 32'd0);
`endif
  endtask

  initial begin
    int acc;
    // Reset behaviour
    idle(1);
    chk("rst_waitreq_hi", 32'(avs_waitrequest), 32'd1);
    chk("rst_rdv_lo", 32'(avs_readdatavalid), 32'd0);
    idle(2);
    reset = 1'b0;
    #1;
    chk("post_rst_waitreq", 32'(avs_waitrequest), 32'd0);
    chk("post_rst_rdata", avs_readdata, 32'd0);
    chk("post_rst_err", 32'(proto_err), 32'd0);
    chk_stats("post_rst", 32'd0, 32'd0);
    idle(1);

    // Write 0xA0..0xA3 with a stall after beat 2, then read back
    wr_burst(32'h0, 16'd4, 32'hA0, 32'd1, 1, 1'b0);
    idle(2);
    rd_burst(32'h0, 16'd4);
    chk_stats("after_s1", 32'd4, 32'd4);
    idle(2);

    // burstcount 0 -> single beat (word 1, unaligned address)
    rd_burst(32'h6, 16'd0);
    idle(2);

    // Wrap past DEPTH-1
    wr_burst(32'(4 * (DEPTH - 2)), 16'd4, 32'd1, 32'd1, -1, 1'b0);
    idle(1);
    rd_burst(32'(4 * (DEPTH - 2)), 16'd4);
    chk("no_err_yet", 32'(proto_err), 32'd0);
    idle(2);

    // Oversized burst: clamped to MAXB beats, error flagged
    wr_burst(32'(4 * 272), 16'd2, 32'hEE0, 32'd1, -1, 1'b0);
    wr_burst(32'(4 * 16), 16'd300, 32'h1000, 32'd1, -1, 1'b0);
    #1;
    chk("clamp_err", 32'(proto_err), 32'd1);
    idle(1);
    rd_burst(32'(4 * 270), 16'd4);
    idle(1);

    // Reset clears the error
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    #1;
    chk("err_cleared", 32'(proto_err), 32'd0);
    idle(1);

    // Read and write together in IDLE: write wins, no beats
    wr_burst(32'h14, 16'd1, 32'h55, 32'd0, -1, 1'b1);
    idle(10);
    chk("rdwr_err", 32'(proto_err), 32'd1);
    rd_burst(32'h14, 16'd1);
    idle(2);

    // Reset in the middle of a read burst, after the first beat
    acc = cyc;
    sb.push_back('{data: mem_m[0], cyc: acc + RL + 1});
    avs_address    = 32'h0;
    avs_burstcount = 16'd4;
    avs_read       = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    idle(RL + 1);
    chk("mid_beat0_seen", 32'(sb.size()), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_waitreq", 32'(avs_waitrequest), 32'd1);
    chk("mid_rst_rdv", 32'(avs_readdatavalid), 32'd0);
    idle(2);
    reset = 1'b0;
    #1;
    chk("mid_post_waitreq", 32'(avs_waitrequest), 32'd0);
    chk_stats("mid_post", 32'd0, 32'd0);
    idle(8);
    rd_burst(32'h0, 16'd4);
    chk_stats("final", 32'd4, 32'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
